// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : arith_pkg

// File: rtl/fullsubtractor_1b.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out).
module fullsubtractor_1b (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fullsubtractor_1b

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = x - y - bin, one bit per clock, LSB first.
// Latency: start edge to done pulse is WIDTH+1 cycles; one result every WIDTH+1 cycles back-to-back.
// Backpressure: start is only accepted in IDLE or DONE; start during SHIFT is ignored.
// Ports: clk, rst (sync, active-high); start/x/y/bin request inputs;
//        busy, done (one-cycle pulse), diff, bout, zero, ovf registered result outputs.
module serial_subtractor_8bit
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   // Operand sign bits are kept aside because xs/ys are shifted away.
   logic             x_msb_q, x_msb_d;
   logic             y_msb_q, y_msb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             fs_d;
   logic             fs_bout;

   fullsubtractor_1b u_fs (
      .a    (xs_q[0]),
      .b    (ys_q[0]),
      .bin  (borrow_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_comb begin
      state_d  = state_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      x_msb_d  = x_msb_q;
      y_msb_d  = y_msb_q;
      bout_d   = bout_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = SHIFT;
               xs_d     = x;
               ys_d     = y;
               borrow_d = bin;
               x_msb_d  = x[WIDTH-1];
               y_msb_d  = y[WIDTH-1];
               cnt_d    = '0;
               sreg_d   = '0;
               bout_d   = 1'b0;
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            xs_d     = xs_q >> 1;
            ys_d     = ys_q >> 1;
            borrow_d = fs_bout;
            // Result fills from the top so after WIDTH shifts bit 0 lands at the LSB.
            sreg_d   = {fs_d, sreg_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               cnt_d   = '0;
               bout_d  = fs_bout;
               zero_d  = (sreg_d == '0);
               // fs_d is the final difference MSB.
               ovf_d   = (x_msb_q != y_msb_q) && (fs_d != x_msb_q);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         xs_q     <= '0;
         ys_q     <= '0;
         sreg_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         x_msb_q  <= 1'b0;
         y_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         x_msb_q  <= x_msb_d;
         y_msb_q  <= y_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = sreg_q;
   assign bout = bout_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule : serial_subtractor_8bit

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial 8-bit subtractor with borrow-in, computing diff = x − y − bin one bit per clock, LSB first. It is the inverse companion of the 8-bit adder in the Digital Systems arithmetic set. It replaces a wide ripple chain with a single 1-bit full-subtractor cell plus shift registers and a borrow flip-flop. A start/busy/done handshake lets a controller issue operands and collect the difference, final borrow and status flags.

## Interface

- WIDTH, 8, operand and result width in bits; the counter is sized to count 0..WIDTH−1.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  minuend, unsigned / two's complement; latched on an accepted start.
- y  input  WIDTH  subtrahend; latched on an accepted start.
- bin  input  1  borrow-in; latched on an accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when results become valid.
- diff  output  WIDTH  x − y − bin, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 when unsigned x < y + bin.
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]), computed from the latched operands.

## Operation

- State machine states: IDLE, SHIFT, DONE.
- IDLE, start=1: latch x→xs, y→ys and bin→borrow; clear count and the diff shift register; go to SHIFT.
- SHIFT, each clock:
  - d = xs[0] ^ ys[0] ^ borrow
  - borrow ← (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & borrow)
  - shift xs and ys right by one; shift d into the diff register at the MSB, so the register fills from the top.
  - count increments.
- SHIFT exit: after the edge that processes bit WIDTH−1, go to DONE and register bout, zero and ovf.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE, giving a back-to-back operation; otherwise go to IDLE.
- start while in SHIFT is ignored. Operands change only on an accepted start.
- diff, bout, zero and ovf hold their values from DONE until the next accepted start. On an accepted start they clear to 0.
- Reset values: state=IDLE; busy, done, diff, bout, zero and ovf all 0; internal registers 0.
- rst has priority over all events. Reset asserted mid-SHIFT aborts the operation: no done pulse, outputs return to their reset values on the next edge.

## Timing

- Cycle 0: start sampled high at the closing edge.
- Cycles 1..WIDTH: busy=1, one bit per cycle.
- Cycle WIDTH+1 (cycle 9 for the default): done=1 and results valid. Latency from the start edge to done is WIDTH+1 cycles.
- Throughput: with start held high in DONE, one result every WIDTH+1 cycles.
- busy and done are never high together. Both are registered outputs; there are no combinational paths from inputs to outputs.

## Structure

- Shared package arith_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - default WIDTH constant
- Sub-module fullsubtractor_1b: combinational, with ports a, b, bin → d, bout. It is instantiated once and also reusable by later parallel subtractors.
- The top module holds the FSM, counter, shift registers, borrow flop and flag logic.

## Test plan

- x=20, y=5, bin=0, start pulse → done in cycle 9; diff=15, bout=0, zero=0, ovf=0.
- x=5, y=20, bin=0 → diff=241 (0xF1), bout=1, ovf=0.
- x=8, y=8, bin=1 → diff=255, bout=1, zero=0. Then x=8, y=8, bin=0 → diff=0, bout=0, zero=1.
- x=0x80, y=0x01, bin=0 → diff=0x7F, ovf=1, bout=0. Then x=0x7F, y=0xFF → diff=0x80, ovf=1, bout=1.
- Start with x=20, y=5, pulse start again in cycle 4 with x=1, y=1 → the second start is ignored; diff=15 in cycle 9. Then hold start high in the DONE cycle with x=3, y=1 → busy in the next cycle, diff=2 exactly 9 cycles later.
- Start x=20, y=5, assert rst in cycle 5 → no done pulse, all outputs 0 from the following edge, state IDLE. A fresh start afterwards completes normally.
